// File: rtl/register_scoreboard.sv
// ---------------------------------------------------------------------------
// register_scoreboard
//   Issue-stage hazard tracker sitting right after the decoder. Keeps one busy
//   bit per general and per float register, stalls issue on RAW/WAW hazards
//   and clears busy bits as the execution units write back.
//
//   Optional build macro: SCOREBOARD_WB_BYPASS_EN
//     defined   - a same-cycle writeback hides the busy bit from the hazard
//                 check, so a stalled instruction can issue in that cycle.
//     undefined - hazard check uses the registered busy bits only.
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   issue_valid/ready     decoded instruction handshake (ready is comb and
//                         independent of issue_valid)
//   src_num/used/float    NSRC source operand slots, 5 bits per slot
//   dst_general/float/num destination register (general wins if both flags)
//   wb_gen_*/wb_flt_*     independent general/float writeback ports
//   flush                 drop all pending writes
//   busy_general/float    registered busy vectors
//   pending_count         registered count of busy bits in both files
//   wb_error              sticky: writeback to a non-busy register or r0
// ---------------------------------------------------------------------------
module register_scoreboard #(
    parameter int NSRC  = 3,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [5*NSRC-1:0] src_num,
    input  logic [NSRC-1:0]   src_used,
    input  logic [NSRC-1:0]   src_float,
    input  logic              dst_general,
    input  logic              dst_float,
    input  logic [4:0]        dst_num,
    input  logic              wb_gen_valid,
    input  logic [4:0]        wb_gen_num,
    input  logic              wb_flt_valid,
    input  logic [4:0]        wb_flt_num,
    input  logic              flush,
    output logic [31:0]       busy_general,
    output logic [31:0]       busy_float,
    output logic [CNT_W-1:0]  pending_count,
    output logic              wb_error
);

    logic [31:0]      r_busy_gen;
    logic [31:0]      r_busy_flt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wb_err;

    logic [31:0]      w_wb_gen_oh;
    logic [31:0]      w_wb_flt_oh;
    logic [31:0]      w_eb_gen;
    logic [31:0]      w_eb_flt;
    logic             w_src_hz;
    logic             w_dst_gen;
    logic             w_dst_flt;
    logic             w_dst_hz;
    logic             w_accept;
    logic [31:0]      w_set_gen;
    logic [31:0]      w_set_flt;
    logic [31:0]      w_nxt_gen;
    logic [31:0]      w_nxt_flt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_wb_bad;

    function automatic logic [CNT_W-1:0] popcnt(input logic [31:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < 32; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // One-hot writeback masks, zero when the port is idle.
    assign w_wb_gen_oh = wb_gen_valid ? (32'd1 << wb_gen_num) : 32'd0;
    assign w_wb_flt_oh = wb_flt_valid ? (32'd1 << wb_flt_num) : 32'd0;

    // Effective busy used by the hazard check.
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_eb_gen = r_busy_gen & ~w_wb_gen_oh;
    assign w_eb_flt = r_busy_flt & ~w_wb_flt_oh;
`else
    assign w_eb_gen = r_busy_gen;
    assign w_eb_flt = r_busy_flt;
`endif

    // RAW check over all used source slots; general r0 never stalls.
    always_comb begin
        w_src_hz = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_used[i]) begin
                if (src_float[i])
                    w_src_hz = w_src_hz | w_eb_flt[src_num[5*i +: 5]];
                else if (src_num[5*i +: 5] != 5'd0)
                    w_src_hz = w_src_hz | w_eb_gen[src_num[5*i +: 5]];
            end
        end
    end

    // Destination decode: general wins when both flags are set, and a general
    // r0 destination is treated as no destination at all.
    assign w_dst_gen = dst_general && (dst_num != 5'd0);
    assign w_dst_flt = dst_float && !dst_general;
    assign w_dst_hz  = (w_dst_gen && w_eb_gen[dst_num]) ||
                       (w_dst_flt && w_eb_flt[dst_num]);

    assign issue_ready = !flush && !w_src_hz && !w_dst_hz;
    assign w_accept    = issue_valid && issue_ready;

    assign w_set_gen = (w_accept && w_dst_gen) ? (32'd1 << dst_num) : 32'd0;
    assign w_set_flt = (w_accept && w_dst_flt) ? (32'd1 << dst_num) : 32'd0;

    // Flush clears everything; a set beats a same-cycle writeback clear.
    always_comb begin
        if (flush) begin
            w_nxt_gen = 32'd0;
            w_nxt_flt = 32'd0;
        end else begin
            w_nxt_gen = (r_busy_gen & ~w_wb_gen_oh) | w_set_gen;
            w_nxt_flt = (r_busy_flt & ~w_wb_flt_oh) | w_set_flt;
        end
        w_nxt_gen[0] = 1'b0;
    end

    assign w_nxt_cnt = popcnt(w_nxt_gen) + popcnt(w_nxt_flt);

    // Writeback to a register that is not busy (or to general r0) is a
    // protocol error from the execution side; judged against registered state.
    assign w_wb_bad = (wb_gen_valid && ((wb_gen_num == 5'd0) || !r_busy_gen[wb_gen_num])) ||
                      (wb_flt_valid && !r_busy_flt[wb_flt_num]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_gen <= 32'd0;
            r_busy_flt <= 32'd0;
            r_cnt      <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy_gen <= w_nxt_gen;
            r_busy_flt <= w_nxt_flt;
            r_cnt      <= w_nxt_cnt;
            if (!flush && w_wb_bad)
                r_wb_err <= 1'b1;
        end
    end

    assign busy_general  = r_busy_gen;
    assign busy_float    = r_busy_flt;
    assign pending_count = r_cnt;
    assign wb_error      = r_wb_err;

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;

    localparam int NSRC  = 3;
    localparam int CNT_W = 7;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_ready;
    logic [5*NSRC-1:0] src_num;
    logic [NSRC-1:0]   src_used;
    logic [NSRC-1:0]   src_float;
    logic              dst_general;
    logic              dst_float;
    logic [4:0]        dst_num;
    logic              wb_gen_valid;
    logic [4:0]        wb_gen_num;
    logic              wb_flt_valid;
    logic [4:0]        wb_flt_num;
    logic              flush;
    logic [31:0]       busy_general;
    logic [31:0]       busy_float;
    logic [CNT_W-1:0]  pending_count;
    logic              wb_error;

    int n_chk  = 0;
    int n_pass = 0;

    register_scoreboard #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .src_num(src_num), .src_used(src_used), .src_float(src_float),
        .dst_general(dst_general), .dst_float(dst_float), .dst_num(dst_num),
        .wb_gen_valid(wb_gen_valid), .wb_gen_num(wb_gen_num),
        .wb_flt_valid(wb_flt_valid), .wb_flt_num(wb_flt_num),
        .flush(flush),
        .busy_general(busy_general), .busy_float(busy_float),
        .pending_count(pending_count), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        iv;
        logic [14:0] sn;
        logic [2:0]  su;
        logic [2:0]  sf;
        logic        dg;
        logic        df;
        logic [4:0]  dn;
        logic        wgv;
        logic [4:0]  wgn;
        logic        wfv;
        logic [4:0]  wfn;
        logic        fl;
        logic        e_rdy;
        logic [31:0] e_bg;
        logic [31:0] e_bf;
        logic [6:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        issue_valid = 0; src_num = '0; src_used = '0; src_float = '0;
        dst_general = 0; dst_float = 0; dst_num = '0;
        wb_gen_valid = 0; wb_gen_num = '0; wb_flt_valid = 0; wb_flt_num = '0;
        flush = 0;
    endtask

    task automatic chk_state(input string nm, input logic [31:0] bg, input logic [31:0] bf,
                             input logic [6:0] cnt, input logic err);
        chk({nm, ".busy_general"}, busy_general, bg);
        chk({nm, ".busy_float"}, busy_float, bf);
        chk({nm, ".pending_count"}, 32'(pending_count), 32'(cnt));
        chk({nm, ".wb_error"}, 32'(wb_error), 32'(err));
    endtask

    // Simple issue of one general destination, no sources; called just after a posedge.
    task automatic issue_gen(input logic [4:0] n);
        idle();
        issue_valid = 1; dst_general = 1; dst_num = n;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(string nm, logic iv, logic [14:0] sn, logic [2:0] su,
                                logic [2:0] sf, logic dg, logic df, logic [4:0] dn,
                                logic wgv, logic [4:0] wgn, logic wfv, logic [4:0] wfn,
                                logic fl, logic rdy, logic [31:0] bg, logic [31:0] bf,
                                logic [6:0] cnt, logic err);
        vec_t v;
        v.name = nm; v.iv = iv; v.sn = sn; v.su = su; v.sf = sf; v.dg = dg; v.df = df;
        v.dn = dn; v.wgv = wgv; v.wgn = wgn; v.wfv = wfv; v.wfn = wfn; v.fl = fl;
        v.e_rdy = rdy; v.e_bg = bg; v.e_bf = bf; v.e_cnt = cnt; v.e_err = err;
        return v;
    endfunction

    initial begin
        //              name        iv sn  su sf dg df dn wgv wgn wfv wfn fl rdy  bg      bf      cnt err
        tbl.push_back(mk("v1_set_r5",  1, 0,  0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1,   32'h20, 32'h0,  1, 0));
        tbl.push_back(mk("v2_raw_r5",  1, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h20, 32'h0,  1, 0));
        tbl.push_back(mk("v3_raw_wb",  1, 5,  1, 0, 0, 0, 0, 1, 5, 0, 0, 0, BYP, 32'h0,  32'h0,  0, 0));
        tbl.push_back(mk("v4_raw_ok",  1, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   32'h0,  32'h0,  0, 0));
        tbl.push_back(mk("v5_set_r5",  1, 0,  0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1,   32'h20, 32'h0,  1, 0));
        tbl.push_back(mk("v6_set_f5",  1, 0,  0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1,   32'h20, 32'h20, 2, 0));
        tbl.push_back(mk("v7_r0",      1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,   32'h20, 32'h20, 2, 0));
        tbl.push_back(mk("v8_set_f7",  1, 0,  0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1,   32'h20, 32'hA0, 3, 0));
        // WAW on busy f7 with same-cycle writeback: bypass issues (set wins), else stall and clear.
        tbl.push_back(mk("v9_waw_wb",  1, 0,  0, 0, 0, 1, 7, 0, 0, 1, 7, 0, BYP, 32'h20,
                         BYP ? 32'hA0 : 32'h20, BYP ? 7'd3 : 7'd2, 0));
        tbl.push_back(mk("v9b_f7",     1, 0,  0, 0, 0, 1, 7, 0, 0, 0, 0, 0, !BYP, 32'h20, 32'hA0, 3, 0));
        // Both dst flags: general wins, busy f7 ignored.
        tbl.push_back(mk("v10_both",   1, 0,  0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 1,   32'hA0, 32'hA0, 4, 0));
        tbl.push_back(mk("v11_wberr",  0, 0,  0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1,   32'hA0, 32'hA0, 4, 1));
        // f9 idle: set wins over the same-cycle (erroneous) writeback.
        tbl.push_back(mk("v12_setwin", 1, 0,  0, 0, 0, 1, 9, 0, 0, 1, 9, 0, 1,   32'hA0, 32'h2A0, 5, 1));
        tbl.push_back(mk("v13_fsrc1",  1, 224, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,   32'hA0, 32'h2A0, 5, 1));
        tbl.push_back(mk("v14_flush",  1, 0,  0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 0,   32'h0,  32'h0,  0, 1));

        idle();
        rst_n = 0;
        #2;
        chk_state("reset", 32'h0, 32'h0, 0, 0);
        chk("reset.issue_ready", 32'(issue_ready), 32'd1);
        #8 rst_n = 1;
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            issue_valid = tbl[k].iv; src_num = tbl[k].sn; src_used = tbl[k].su;
            src_float = tbl[k].sf; dst_general = tbl[k].dg; dst_float = tbl[k].df;
            dst_num = tbl[k].dn; wb_gen_valid = tbl[k].wgv; wb_gen_num = tbl[k].wgn;
            wb_flt_valid = tbl[k].wfv; wb_flt_num = tbl[k].wfn; flush = tbl[k].fl;
            #1;
            chk({tbl[k].name, ".ready"}, 32'(issue_ready), 32'(tbl[k].e_rdy));
            @(posedge clk); #1;
            chk_state(tbl[k].name, tbl[k].e_bg, tbl[k].e_bf, tbl[k].e_cnt, tbl[k].e_err);
        end
        idle();

        // wb_error survived the flush; only reset clears it (asynchronously).
        #3 rst_n = 0;
        #1 chk_state("rst_err", 32'h0, 32'h0, 0, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Writeback to general r0 is an error.
        idle(); wb_gen_valid = 1; wb_gen_num = 0;
        @(posedge clk); #1;
        chk_state("wb_r0", 32'h0, 32'h0, 0, 1);

        // Ten busy registers, then flush with a valid issue pending.
        for (int r = 1; r <= 10; r++) issue_gen(5'(r));
        idle();
        chk_state("ten_busy", 32'h7FE, 32'h0, 10, 1);
        issue_valid = 1; dst_general = 1; dst_num = 20; flush = 1;
        #1 chk("flush10.ready", 32'(issue_ready), 32'd0);
        @(posedge clk); #1;
        idle();
        chk_state("flush10", 32'h0, 32'h0, 0, 1);

        // Mid-cycle reset pulse clears outputs without a clock edge.
        issue_gen(5'd12);
        idle();
        chk_state("pre_rst", 32'h1000, 32'h0, 1, 1);
        #2 rst_n = 0;
        #1 chk_state("async_rst", 32'h0, 32'h0, 0, 0);
        rst_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
